// File: rtl/mux_scan_ctrl.sv
// Scan controller for an external 4:1 mux: steps the select through 0..3, samples
// each input after a settle period and presents the assembled word with valid/ready.
module mux_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mux_out,
  input  logic       ready,
  output logic [1:0] sel,
  output logic [3:0] data_out,
  output logic       valid,
  output logic       busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cap_q, cap_d;
  logic [3:0] data_q, data_d;
  logic [1:0] sel_q, sel_d;
  logic       valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          idx_d   = 2'd0;
          cnt_d   = 4'd0;
          cap_d   = 4'd0;
          sel_d   = 2'd0;
        end
      end
      SCAN: begin
        if (cnt_q == LAST_CNT) begin
          cap_d[idx_q] = mux_out;
          cnt_d        = 4'd0;
          // The last bit goes straight into the output word, bypassing the capture register
          if (idx_q == 2'd3) begin
            state_d = HOLD;
            data_d  = {mux_out, cap_q[2:0]};
            valid_d = 1'b1;
            sel_d   = 2'd0;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
            sel_d = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOLD: begin
        if (ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        sel_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      cap_q   <= 4'd0;
      data_q  <= 4'd0;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign sel      = sel_q;
  assign data_out = data_q;
  assign valid    = valid_q;
  assign busy     = (state_q == SCAN) || (state_q == HOLD);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl: two instances (SETTLE=1 and SETTLE=3), each driving a
// modelled 4:1 mux, checked against a timing model derived from the scan rules.
module tb_mux_scan_ctrl;

  localparam int S0 = 1;
  localparam int S1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_v;
  logic [1:0] start_v;
  logic [1:0] ready_v;
  logic [1:0] valid_v;
  logic [1:0] busy_v;
  logic [1:0] noise_en;
  logic [1:0] noise_bit;
  logic [1:0] sel0, sel1;
  logic [3:0] data0, data1;
  logic [3:0] word_v [2];
  logic       mux0, mux1;

  int passed = 0;
  int total  = 0;

  // The mux itself: selected bit of the word, or a random bit on non-sampling cycles
  assign mux0 = noise_en[0] ? noise_bit[0] : word_v[0][sel0];
  assign mux1 = noise_en[1] ? noise_bit[1] : word_v[1][sel1];

  mux_scan_ctrl #(.SETTLE(S0)) dut0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .mux_out(mux0), .ready(ready_v[0]),
    .sel(sel0), .data_out(data0), .valid(valid_v[0]), .busy(busy_v[0])
  );

  mux_scan_ctrl #(.SETTLE(S1)) dut1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .mux_out(mux1), .ready(ready_v[1]),
    .sel(sel1), .data_out(data1), .valid(valid_v[1]), .busy(busy_v[1])
  );

  function automatic int settle_of(input int d);
    return (d == 0) ? S0 : S1;
  endfunction

  function automatic logic [1:0] sel_of(input int d);
    return (d == 0) ? sel0 : sel1;
  endfunction

  function automatic logic [3:0] data_of(input int d);
    return (d == 0) ? data0 : data1;
  endfunction

  // One complete scan/transfer: sel must step (k-1)/SETTLE in cycle k, valid appears at 4*SETTLE+1
  task automatic run_scan(input int d, input logic [3:0] word, input int hold_cycles,
                          input bit hold_start, input bit use_noise, input string tag);
    int s;
    int exp_sel;
    bit capture;
    s = settle_of(d);
    word_v[d]  = word;
    start_v[d] = 1'b1;
    @(negedge clk);
    if (!hold_start) start_v[d] = 1'b0;
    for (int k = 1; k <= 4 * s; k++) begin
      exp_sel = (k - 1) / s;
      capture = ((k - 1) % s) == (s - 1);
      noise_en[d]  = use_noise && !capture;
      noise_bit[d] = 1'($urandom);
      ready_v[d]   = 1'($urandom);
      total++;
      if (sel_of(d) !== 2'(exp_sel)) $display("[TB] FAIL %s scan_sel k=%0d got=%0d exp=%0d", tag, k, sel_of(d), exp_sel);
      else passed++;
      total++;
      if (busy_v[d] !== 1'b1 || valid_v[d] !== 1'b0) $display("[TB] FAIL %s scan_flags k=%0d busy=%b valid=%b exp busy=1 valid=0", tag, k, busy_v[d], valid_v[d]);
      else passed++;
      @(negedge clk);
    end
    noise_en[d] = 1'b0;
    ready_v[d]  = 1'b0;
    total++;
    if (valid_v[d] !== 1'b1 || busy_v[d] !== 1'b1) $display("[TB] FAIL %s valid_latency valid=%b busy=%b exp 1 1", tag, valid_v[d], busy_v[d]);
    else passed++;
    total++;
    if (data_of(d) !== word || sel_of(d) !== 2'd0) $display("[TB] FAIL %s hold_word data=%b sel=%0d exp data=%b sel=0", tag, data_of(d), sel_of(d), word);
    else passed++;
    for (int h = 0; h < hold_cycles; h++) begin
      noise_en[d]  = 1'b1;
      noise_bit[d] = 1'($urandom);
      @(negedge clk);
      total++;
      if (valid_v[d] !== 1'b1 || data_of(d) !== word) $display("[TB] FAIL %s backpressure h=%0d valid=%b data=%b exp 1 %b", tag, h, valid_v[d], data_of(d), word);
      else passed++;
    end
    noise_en[d] = 1'b0;
    ready_v[d]  = 1'b1;
    @(negedge clk);
    ready_v[d] = 1'b0;
    start_v[d] = 1'b0;
    total++;
    if (valid_v[d] !== 1'b0 || busy_v[d] !== 1'b0) $display("[TB] FAIL %s accept valid=%b busy=%b exp 0 0", tag, valid_v[d], busy_v[d]);
    else passed++;
    total++;
    if (data_of(d) !== word || sel_of(d) !== 2'd0) $display("[TB] FAIL %s after_accept data=%b sel=%0d exp %b 0", tag, data_of(d), sel_of(d), word);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      ready_v[d] = 1'($urandom);
      @(negedge clk);
      total++;
      if (busy_v[d] !== 1'b0 || valid_v[d] !== 1'b0) $display("[TB] FAIL %s idle_after i=%0d busy=%b valid=%b exp 0 0", tag, i, busy_v[d], valid_v[d]);
      else passed++;
    end
    ready_v[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_v   = 2'b11;
    start_v = 2'b11;
    ready_v = 2'b11;
    repeat (2) @(negedge clk);
    total++;
    if (sel0 !== 2'd0 || sel1 !== 2'd0) $display("[TB] FAIL reset_sel got=%0d,%0d exp=0,0", sel0, sel1);
    else passed++;
    total++;
    if (valid_v !== 2'b00 || busy_v !== 2'b00) $display("[TB] FAIL reset_flags valid=%b busy=%b exp 00 00", valid_v, busy_v);
    else passed++;
    total++;
    if (data0 !== 4'b0000 || data1 !== 4'b0000) $display("[TB] FAIL reset_data got=%b,%b exp=0000,0000", data0, data1);
    else passed++;
    rst_v   = 2'b00;
    start_v = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (busy_v !== 2'b00 || valid_v !== 2'b00) $display("[TB] FAIL reset_idle i=%0d busy=%b valid=%b exp 00 00", i, busy_v, valid_v);
      else passed++;
    end
    ready_v = 2'b00;
  endtask

  task automatic test_basic_scan();
    run_scan(0, 4'b1010, 0, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_backpressure();
    run_scan(0, 4'b1010, 10, 1'b0, 1'b0, "backpressure");
  endtask

  task automatic test_ignored_start();
    run_scan(0, 4'b0011, 2, 1'b1, 1'b0, "ignored_start");
  endtask

  task automatic test_settle();
    run_scan(1, 4'b0110, 1, 1'b0, 1'b1, "settle3");
  endtask

  task automatic test_mid_reset(input int d);
    int s;
    s = settle_of(d);
    word_v[d]  = 4'b1100;
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    for (int k = 1; k <= 2 * s; k++) @(negedge clk);
    total++;
    if (sel_of(d) !== 2'd2) $display("[TB] FAIL mid_reset_pre d=%0d sel=%0d exp=2", d, sel_of(d));
    else passed++;
    rst_v[d]   = 1'b1;
    start_v[d] = 1'b1;
    @(negedge clk);
    rst_v[d]   = 1'b0;
    start_v[d] = 1'b0;
    total++;
    if (sel_of(d) !== 2'd0 || valid_v[d] !== 1'b0 || busy_v[d] !== 1'b0 || data_of(d) !== 4'b0000)
      $display("[TB] FAIL mid_reset d=%0d sel=%0d valid=%b busy=%b data=%b exp all zero", d, sel_of(d), valid_v[d], busy_v[d], data_of(d));
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if (busy_v[d] !== 1'b0 || data_of(d) !== 4'b0000) $display("[TB] FAIL mid_reset_idle d=%0d busy=%b data=%b exp 0 0000", d, busy_v[d], data_of(d));
    else passed++;
    run_scan(d, 4'b1111, 2, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      run_scan($urandom_range(0, 1), 4'($urandom), $urandom_range(0, 4),
               1'($urandom), 1'b1, "random");
    end
  endtask

  initial begin
    rst_v     = 2'b11;
    start_v   = 2'b00;
    ready_v   = 2'b00;
    noise_en  = 2'b00;
    noise_bit = 2'b00;
    word_v[0] = 4'b0000;
    word_v[1] = 4'b0000;
    @(negedge clk);
    test_reset();
    test_basic_scan();
    test_backpressure();
    test_ignored_start();
    test_settle();
    test_mid_reset(0);
    test_mid_reset(1);
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 1, SHALL set the cycles each select value is held before sampling; legal range 1..15.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 start  input  1  SHALL request one scan of all four mux inputs; single-cycle pulse or level.
REQ-005 sel  output  2  SHALL drive the 2-bit select of the downstream 4:1 mux.
REQ-006 mux_out  input  1  SHALL carry the 1-bit data output of that mux.
REQ-007 data_out  output  4  SHALL hold the assembled word; bit i is mux_out sampled while sel==i.
REQ-008 valid  output  1  SHALL flag data_out as a complete word awaiting acceptance.
REQ-009 ready  input  1  SHALL indicate the consumer accepts data_out; transfer occurs when valid && ready.
REQ-010 busy  output  1  SHALL be high in states SCAN and HOLD.

Function
REQ-011 The FSM SHALL have three states: IDLE, SCAN and HOLD.
REQ-012 In IDLE: sel=0, valid=0, busy=0; start=1 SHALL move to SCAN with idx=0 and settle counter=0 on the next edge.
REQ-013 In SCAN, sel SHALL equal idx (2-bit index), registered so that it changes only on a clock edge.
REQ-014 In SCAN, the settle counter SHALL count 0..SETTLE-1 per index.
- On the edge where the counter equals SETTLE-1, mux_out SHALL be captured into shift/capture bit idx.
- On that same edge, idx SHALL increment and the counter SHALL clear.
REQ-015 After capture of idx==3, the FSM SHALL enter HOLD.
- data_out SHALL load all four captured bits.
- valid SHALL go to 1 on the same edge.
- sel SHALL return to 0.
REQ-016 Latency SHALL be exactly 4*SETTLE+1 cycles from the edge sampling start=1 in IDLE to the first cycle valid=1 (5 cycles for SETTLE=1).
REQ-017 In HOLD, valid and data_out SHALL remain stable until valid && ready is sampled.
REQ-018 On a valid && ready edge, the FSM SHALL go to IDLE.
- valid and busy SHALL drop on that edge.
- data_out SHALL retain its last value.
REQ-019 start SHALL be ignored while in SCAN or HOLD, including start=1 coincident with the accepting valid && ready edge; a new scan requires start sampled in IDLE.
REQ-020 ready SHALL be ignored outside HOLD.
REQ-021 idx SHALL never wrap within one scan; exactly four samples per scan, in order 0,1,2,3.
REQ-022 mux_out SHALL be sampled only on capture edges; its value at other cycles SHALL have no effect.

Reset
REQ-023 rst=1 SHALL, on the next edge, force: state IDLE, sel=0, valid=0, busy=0, data_out=0, idx=0, settle counter=0, capture bits=0.
REQ-024 rst SHALL take priority over start, ready and any in-progress scan or HOLD; a partially captured word SHALL be discarded.
REQ-025 After rst deasserts, the block SHALL remain in IDLE until start is sampled high.

Verification
REQ-026 Reset: rst high 2 cycles with start=1 -> sel=0, valid=0, busy=0, data_out=4'b0000; IDLE persists after release until a fresh start.
REQ-027 Basic scan: SETTLE=1, mux In=4'b1010, start pulse at cycle 0 -> sel=0,1,2,3 in cycles 1-4, valid=1 at cycle 5, data_out=4'b1010.
REQ-028 Backpressure: ready=0 for 10 cycles in HOLD -> valid=1 and data_out=4'b1010 stable throughout; ready=1 -> valid=0, busy=0 next cycle.
REQ-029 Ignored start: start held high during SCAN and on the accepting edge -> exactly one scan and one transfer; IDLE reached, no rescan.
REQ-030 Settle: SETTLE=3, In=4'b0110 -> each sel value held 3 cycles, valid at cycle 13, data_out=4'b0110.
REQ-031 Mid-scan reset: rst at first cycle of sel=2 -> next cycle IDLE, all outputs zero; subsequent start with In=4'b1111 -> data_out=4'b1111.
